// File: rtl/naval_pkg.sv
// naval_pkg: shared definitions for the naval-battle placement blocks.
//   - piece type codes (SUB..PAV) and their default per-player quotas
//   - placement sequencer state encoding (3-bit binary)
//   - board geometry
package naval_pkg;

    typedef enum logic [2:0] {
        SUB = 3'd0,
        CRU = 3'd1,
        HID = 3'd2,
        ENC = 3'd3,
        PAV = 3'd4
    } piece_e;

    localparam int DEF_N_SUB = 5;
    localparam int DEF_N_CRU = 2;
    localparam int DEF_N_HID = 2;
    localparam int DEF_N_ENC = 1;
    localparam int DEF_N_PAV = 1;

    localparam int BOARD_W = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT     = 3'd1;
    localparam logic [2:0] ST_VALIDATE = 3'd2;
    localparam logic [2:0] ST_COMMIT   = 3'd3;
    localparam logic [2:0] ST_ADVANCE  = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

endpackage

// File: rtl/fleet_quota_counter.sv
// fleet_quota_counter: tracks which piece of one player's fleet is being placed.
//   clk, reset     : clock, async active-low reset
//   clear          : load the start of a fleet (first type with a nonzero quota)
//   advance        : current piece committed, step to the next one
//   piece_type     : current type code 0..4
//   piece_idx      : index within current type
//   pieces_left    : pieces still to place, including the current one
//   last           : current piece is the final one of this fleet
module fleet_quota_counter
    import naval_pkg::*;
#(
    parameter int N_SUB = DEF_N_SUB,
    parameter int N_CRU = DEF_N_CRU,
    parameter int N_HID = DEF_N_HID,
    parameter int N_ENC = DEF_N_ENC,
    parameter int N_PAV = DEF_N_PAV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    output logic [2:0] piece_type,
    output logic [2:0] piece_idx,
    output logic [3:0] pieces_left,
    output logic       last
);

    localparam int TOTAL = N_SUB + N_CRU + N_HID + N_ENC + N_PAV;
    localparam logic [3:0] TOTAL4 = 4'(TOTAL);

    generate
        if (TOTAL > 15 || TOTAL < 1) begin : g_bad_total
            $error("fleet_quota_counter: fleet total must be 1..15");
        end
    endgenerate

    function automatic logic [3:0] quota(input logic [2:0] t);
        case (t)
            SUB:     quota = 4'(N_SUB);
            CRU:     quota = 4'(N_CRU);
            HID:     quota = 4'(N_HID);
            ENC:     quota = 4'(N_ENC);
            PAV:     quota = 4'(N_PAV);
            default: quota = 4'd0;
        endcase
    endfunction

    // First type at or above 'from' with a nonzero quota; types with an
    // empty quota are skipped entirely.
    function automatic logic [2:0] next_type(input logic [2:0] from);
        logic       found;
        next_type = from;
        found     = 1'b0;
        for (int t = 0; t < 5; t++) begin
            if (!found && 3'(t) >= from && quota(3'(t)) != 4'd0) begin
                next_type = 3'(t);
                found     = 1'b1;
            end
        end
    endfunction

    logic       type_done;

    assign last      = (pieces_left == 4'd1);
    assign type_done = ({1'b0, piece_idx} + 4'd1) == quota(piece_type);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            piece_type  <= 3'd0;
            piece_idx   <= 3'd0;
            pieces_left <= TOTAL4;
        end else if (clear) begin
            piece_type  <= next_type(3'd0);
            piece_idx   <= 3'd0;
            pieces_left <= TOTAL4;
        end else if (advance) begin
            if (last) begin
                // fleet complete: type/idx hold on the final piece
                pieces_left <= 4'd0;
            end else begin
                pieces_left <= pieces_left - 4'd1;
                if (type_done) begin
                    piece_idx  <= 3'd0;
                    piece_type <= next_type(piece_type + 3'd1);
                end else begin
                    piece_idx <= piece_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/fleet_placement_sequencer.sv
// fleet_placement_sequencer: steps both players through fleet placement,
// runs the validator handshake with timeout/retry and strobes board writes.
//   clk, reset    : clock, async active-low reset
//   start, mode   : begin placement; mode 0 = P1 x CPU, 1 = P1 x P2 (latched)
//   place_req     : coords ready from placement FSM (honoured in WAIT_COORD)
//   val_ack       : validator result valid; val_conflict qualifies it
//   piece_type, piece_idx, pieces_left : current piece position in the fleet
//   player        : board being filled / memory select
//   cpu_turn      : CPU placer supplies coordinates
//   place_en, val_req, mem_we, retry, ready : handshake and status outputs
module fleet_placement_sequencer
    import naval_pkg::*;
#(
    parameter int N_SUB       = DEF_N_SUB,
    parameter int N_CRU       = DEF_N_CRU,
    parameter int N_HID       = DEF_N_HID,
    parameter int N_ENC       = DEF_N_ENC,
    parameter int N_PAV       = DEF_N_PAV,
    parameter int VAL_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mode,
    input  logic       place_req,
    input  logic       val_ack,
    input  logic       val_conflict,
    output logic [2:0] piece_type,
    output logic [2:0] piece_idx,
    output logic       player,
    output logic       cpu_turn,
    output logic       place_en,
    output logic       val_req,
    output logic       mem_we,
    output logic       retry,
    output logic [3:0] pieces_left,
    output logic       ready
);

    localparam int TW = (VAL_TIMEOUT > 2) ? $clog2(VAL_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(VAL_TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q;
    logic          mode_q;
    logic          retry_d;
    logic          clear, advance, last;
    logic          timed_out;

    fleet_quota_counter #(
        .N_SUB(N_SUB), .N_CRU(N_CRU), .N_HID(N_HID), .N_ENC(N_ENC), .N_PAV(N_PAV)
    ) u_quota (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .advance     (advance),
        .piece_type  (piece_type),
        .piece_idx   (piece_idx),
        .pieces_left (pieces_left),
        .last        (last)
    );

    // ack in the final timer cycle wins over the timeout
    assign timed_out = !val_ack && (timer_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        advance = 1'b0;
        retry_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    clear   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (place_req) state_d = ST_VALIDATE;
            end
            ST_VALIDATE: begin
                if (val_ack && !val_conflict) begin
                    state_d = ST_COMMIT;
                end else if ((val_ack && val_conflict) || timed_out) begin
                    state_d = ST_WAIT;
                    retry_d = 1'b1;
                end
            end
            ST_COMMIT:  state_d = ST_ADVANCE;
            ST_ADVANCE: begin
                advance = 1'b1;
                if (!last) begin
                    state_d = ST_WAIT;
                end else if (!player) begin
                    // hand over to player 1: restart the fleet counter
                    clear   = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            mode_q  <= 1'b0;
            player  <= 1'b0;
            retry   <= 1'b0;
        end else begin
            state_q <= state_d;
            retry   <= retry_d;
            timer_q <= (state_q == ST_VALIDATE) ? timer_q + 1'b1 : '0;
            if (state_q == ST_IDLE && start) begin
                mode_q <= mode;
                player <= 1'b0;
            end else if (state_q == ST_ADVANCE && last && !player) begin
                player <= 1'b1;
            end
        end
    end

    assign place_en = (state_q == ST_WAIT);
    assign val_req  = (state_q == ST_VALIDATE);
    assign mem_we   = (state_q == ST_COMMIT);
    assign ready    = (state_q == ST_DONE);
    assign cpu_turn = player && !mode_q;

endmodule

// File: tb/tb_fleet_placement_sequencer.sv
module tb_fleet_placement_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, mode = 1'b0, place_req = 1'b0;
    logic       val_ack = 1'b0, val_conflict = 1'b0;
    logic [2:0] piece_type, piece_idx;
    logic       player, cpu_turn, place_en, val_req, mem_we, retry, ready;
    logic [3:0] pieces_left;

    int errors = 0;
    int checks = 0;

    fleet_placement_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .place_req(place_req), .val_ack(val_ack), .val_conflict(val_conflict),
        .piece_type(piece_type), .piece_idx(piece_idx), .player(player),
        .cpu_turn(cpu_turn), .place_en(place_en), .val_req(val_req),
        .mem_we(mem_we), .retry(retry), .pieces_left(pieces_left), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait for place_en, issue place_req, hold off dly cycles in VALIDATE,
    // then return the validator answer. Returns one cycle after the ack.
    task automatic place(input logic conf, input int dly);
        int n = 0;
        while (!place_en && n < 50) begin tick; n++; end
        if (!place_en) chk("place_en_wait", 0, 1);
        place_req = 1'b1; tick; place_req = 1'b0;
        chk("val_req_up", val_req, 1);
        repeat (dly) tick;
        val_ack = 1'b1; val_conflict = conf; tick;
        val_ack = 1'b0; val_conflict = 1'b0;
    endtask

    int quota [5] = '{5, 2, 2, 1, 1};
    int e_type, e_idx, e_left, e_player, n_we;

    initial begin
        // reset state
        #12;
        chk("rst_left", pieces_left, 11);
        chk("rst_place_en", place_en, 0);
        chk("rst_ready", ready, 0);
        chk("rst_val_req", val_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_player", player, 0);
        chk("rst_type", piece_type, 0);
        reset = 1'b1;
        tick;
        place_req = 1'b1; tick; place_req = 1'b0;
        chk("idle_ignores_req", val_req, 0);

        // start in P1 x CPU, then flip mode: latched value must stick
        start = 1'b1; mode = 1'b0; tick; start = 1'b0;
        chk("start_place_en", place_en, 1);
        mode = 1'b1;

        // ack while waiting for coords is ignored
        val_ack = 1'b1; tick; val_ack = 1'b0;
        chk("stray_ack_mem_we", mem_we, 0);
        chk("stray_ack_place_en", place_en, 1);

        e_type = 0; e_idx = 0; e_left = 11; e_player = 0; n_we = 0;
        for (int i = 0; i < 22; i++) begin
            if (i == 2) begin
                place(1'b1, 1);
                chk("conf_retry", retry, 1);
                chk("conf_mem_we", mem_we, 0);
                chk("conf_place_en", place_en, 1);
                chk("conf_idx", piece_idx, 2);
                tick;
                chk("conf_retry_pulse", retry, 0);
            end
            if (i == 4) begin
                // no ack: 15 cycles of val_req, then retry
                place_req = 1'b1; tick; place_req = 1'b0;
                repeat (14) tick;
                chk("tmo_still_req", val_req, 1);
                tick;
                chk("tmo_val_req", val_req, 0);
                chk("tmo_retry", retry, 1);
                chk("tmo_place_en", place_en, 1);
                chk("tmo_idx", piece_idx, 4);
                place(1'b0, 14);   // ack in the 15th cycle wins
                chk("tmo_edge_retry", retry, 0);
            end else begin
                place(1'b0, i % 3);
            end
            chk("mem_we", mem_we, 1);
            if (mem_we) n_we++;
            chk("we_player", player, e_player);
            chk("cpu_turn", cpu_turn, e_player);
            tick;
            chk("we_pulse", mem_we, 0);
            tick;
            // reference model of the fleet order
            if (e_left == 1) begin
                if (e_player == 0) begin
                    e_player = 1; e_type = 0; e_idx = 0; e_left = 11;
                end else begin
                    e_left = 0;
                end
            end else begin
                e_left--; e_idx++;
                if (e_idx == quota[e_type]) begin e_idx = 0; e_type++; end
            end
            if (i < 21) begin
                chk("type", piece_type, e_type);
                chk("idx", piece_idx, e_idx);
                chk("left", pieces_left, e_left);
                chk("player", player, e_player);
            end
            if (i == 4) begin
                chk("c5_type", piece_type, 1);
                chk("c5_idx", piece_idx, 0);
                chk("c5_left", pieces_left, 6);
            end
            if (i == 8)  chk("c9_type", piece_type, 3);
            if (i == 10) begin
                chk("c11_player", player, 1);
                chk("c11_type", piece_type, 0);
                chk("c11_left", pieces_left, 11);
                chk("c11_cpu", cpu_turn, 1);
            end
        end
        chk("we_count", n_we, 22);
        chk("done_ready", ready, 1);
        chk("done_place_en", place_en, 0);
        start = 1'b1; tick; tick; start = 1'b0;
        chk("done_hold", ready, 1);

        // async reset in the middle of VALIDATE
        reset = 1'b0; #2; reset = 1'b1;
        tick;
        start = 1'b1; mode = 1'b1; tick; start = 1'b0;
        place_req = 1'b1; tick; place_req = 1'b0;
        chk("pre_rst_val_req", val_req, 1);
        #3 reset = 1'b0; #1;
        chk("arst_val_req", val_req, 0);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_left", pieces_left, 11);
        chk("arst_ready", ready, 0);
        chk("arst_place_en", place_en, 0);
        reset = 1'b1;
        tick;
        chk("arst_idle", place_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
